// File: rtl/sccb_slave_regfile_if.sv
// SCCB/I2C target with 16-bit register addressing, oversampled on clk_25M.
// Decodes START/STOP/bytes, drives ACK and read data open-drain, and exposes a register-file port.
module sccb_slave_regfile_if #(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_25M,
    input  logic        camera_rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic [7:0]  nack_cnt
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, ADDR_H, AH_ACK, ADDR_L, AL_ACK, WDATA, WD_ACK, RDATA, RD_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   rd_mode;
    logic                   rd_ack_ok;

    // Sync flops preset high so a reset never looks like a START or an SCL edge.
    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            busy      <= 1'b0;
            nack_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rd_mode   <= 1'b0;
            rd_ack_ok <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so any branch that sets them yields a single-cycle pulse.
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state     <= DEV;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
                bit_cnt   <= '0;
                rd_ack_ok <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    DEV, ADDR_H, ADDR_L, WDATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == WDATA && bit_cnt == 4'd7) begin
                                reg_wdata <= {shift[6:0], sda_s};
                                reg_wr_en <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b1;
                            case (state)
                                DEV: begin
                                    if (shift[7:1] == DEV_ADDR) begin
                                        state   <= DEV_ACK;
                                        rd_mode <= shift[0];
                                    end else begin
                                        state  <= IDLE;
                                        sda_oe <= 1'b0;
                                        busy   <= 1'b0;
                                        if (nack_cnt != 8'hFF) nack_cnt <= nack_cnt + 8'd1;
                                    end
                                end
                                ADDR_H: begin
                                    reg_addr[15:8] <= shift;
                                    state          <= AH_ACK;
                                end
                                ADDR_L: begin
                                    reg_addr[7:0] <= shift;
                                    state         <= AL_ACK;
                                end
                                default: state <= WD_ACK;
                            endcase
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            if (rd_mode) begin
                                state     <= RDATA;
                                reg_rd_en <= 1'b1;
                            end else begin
                                state <= ADDR_H;
                            end
                        end
                    end
                    AH_ACK: if (scl_fall) begin sda_oe <= 1'b0; state <= ADDR_L; end
                    AL_ACK: if (scl_fall) begin sda_oe <= 1'b0; state <= WDATA; end
                    WD_ACK: begin
                        if (scl_fall) begin
                            sda_oe   <= 1'b0;
                            reg_addr <= reg_addr + 16'd1;
                            state    <= WDATA;
                        end
                    end
                    RDATA: begin
                        // First bit goes out as soon as the bank answers the read request.
                        if (reg_rd_en) begin
                            shift  <= reg_rdata;
                            sda_oe <= ~reg_rdata[7];
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state     <= RD_ACK;
                                sda_oe    <= 1'b0;
                                bit_cnt   <= '0;
                                rd_ack_ok <= 1'b0;
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        // Next byte is fetched on the master ACK but only driven after SCL falls.
                        if (reg_rd_en) begin
                            shift <= reg_rdata;
                        end else if (scl_rise) begin
                            if (!sda_s) begin
                                rd_ack_ok <= 1'b1;
                                reg_addr  <= reg_addr + 16'd1;
                                reg_rd_en <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (scl_fall && rd_ack_ok) begin
                            state   <= RDATA;
                            sda_oe  <= ~shift[7];
                            bit_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
